mazegen_bt: RTL and testbench
=============================

# mazegen_bt

Parametrised binary-tree maze generator; successor to `mazegen`, with independent width and height, a start/busy/done handshake, restart without reset, a run-time north/east bias and a registered row-read port in place of the full-array output. It fills an H×W wall bitmap from a 16-bit seed, one cell per clock. Downstream logic (renderer, file dump, solver) reads rows back through `rd_addr`/`rd_data`.

## Interface

- `W`, 9, grid width in bits; odd, ≥3
- `H`, 9, grid height in rows; odd, ≥3
- `AW`, `$clog2(H)`, row address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin generation; sampled in IDLE or DONE only
- `seed`  in  16  LFSR seed, captured on accepted `start`
- `bias`  in  4  north-carve threshold for interior cells
- `busy`  out  1  high from the cycle after accepted `start` until generation completes
- `done`  out  1  level; high from completion until the next accepted `start`
- `rd_addr`  in  AW  row to read
- `rd_data`  out  W  registered row data; bit x = column x; 1 = wall, 0 = open

## Operation

- Storage: H rows × W bits of flops. Row 0 is the top row.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400), shift right. Loaded with `seed` on accepted `start`; seed 0x0000 is replaced with 0xACE1. Advances exactly once per CARVE cycle.
- FSM states:
  - IDLE: waits for `start`.
  - CLEAR: writes all-ones to one row per cycle, rows 0..H-1, for H cycles.
  - CARVE: visits cells (x,y) with x,y odd, x in 1..W-2, y in 1..H-2, row-major with x inner. One cell per cycle; NC = ((W-1)/2)·((H-1)/2) cycles.
  - DONE: holds the maze until the next `start`.
- Transitions:
  - IDLE→CLEAR on `start`.
  - CLEAR→CARVE after row H-1.
  - CARVE→DONE after the last cell.
  - DONE→CLEAR on `start`.
  - `start` in CLEAR or CARVE is ignored.
- Carve rule per cell (the cell bit itself is always cleared to 0):
  - top row (y=1) and x≠W-2: clear east wall (x+1,y).
  - right column (x=W-2) and y≠1: clear north wall (x,y-1).
  - corner (W-2,1): no wall cleared.
  - otherwise: clear north if LFSR[3:0] < `bias`, else clear east. `bias` is sampled every cycle.
  - `bias`=0 → all interior cells carve east.
- Result is a perfect maze: every open cell is reachable and there are no loops. The border stays all walls.
- Reads:
  - `rd_data` <= row[`rd_addr`] on every clock, in any state, including while busy; reads during generation return in-progress contents.
  - `rd_addr` ≥ H returns all zeros.

## Timing

- Reset (`rst` low, asynchronous): FSM=IDLE, `busy`=0, `done`=0, `rd_data`=0, all storage rows all-ones, LFSR=0xACE1.
- Reset asserted mid-generation aborts immediately; no partial result is kept.
- `start` is accepted at edge k (IDLE/DONE): `busy`=1 and `done`=0 from k+1. CLEAR occupies edges k+1..k+H; CARVE occupies k+H+1..k+H+NC.
- At edge k+H+NC+1: `busy`=0, `done`=1. `busy` and `done` are never both high.
- Restart from DONE drops `done` on the following edge; the old maze is overwritten during CLEAR.
- `start` high during the edge where `rst` is low is ignored. Held `start` is accepted at the first edge after reset release.
- Read latency: 1 cycle from `rd_addr` to `rd_data`.
- Total latency for W=H=9: 9 + 16 = 25 cycles from accept to `done`.

## Test plan

- Reset: hold `rst` low, then release. Required: `busy`=`done`=0, `rd_data`=0, and every row reads as all-ones.
- W=H=5, `bias`=0, any seed, `start` at edge k. Required rows 0..4: 5'b11111, 5'b10001, 5'b10111, 5'b10001, 5'b11111. `done` rises at edge k+10.
- W=H=9, seed 0x0000 vs seed 0xACE1. Required: identical mazes. Also required: open-cell count = 2·16−1 = 31 and BFS connectivity from (1,1) reaches all 16 cells.
- Restart and ignore: `start` pulsed mid-CARVE has no effect on timing or result. `start` in DONE with a new seed: `done` low next cycle, and the new maze matches the reference model.
- Reset mid-operation: `rst` low at cycle k+H+3 of a run. Required: immediate IDLE, `busy`=0, all rows all-ones. A subsequent `start` produces the full correct maze.
- Asymmetric size W=15, H=7, random seeds × 50 and `bias` sweep 0..15. Required: every maze matches the bit-exact software model, and `rd_addr`=7 returns 0.

Source files
------------

// File: rtl/mazegen_bt.sv
// rtl/mazegen_bt.sv - binary-tree maze generator with registered row-read port
//
// Fills an H x W wall bitmap (1 = wall, 0 = open) one cell per clock from a
// 16-bit seed. Odd (x,y) cells are carved in row-major order; each cell opens
// itself plus either its north or its east neighbour wall.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    begin generation (accepted only in IDLE or DONE)
//   seed     LFSR seed, captured on accepted start (0 -> 0xACE1)
//   bias     north-carve threshold for interior cells, sampled every cycle
//   busy     high while clearing or carving
//   done     level, high from completion until the next accepted start
//   rd_addr  row to read
//   rd_data  registered row contents, bit x = column x; 0 for rd_addr >= H
module mazegen_bt #(
  parameter int W  = 9,
  parameter int H  = 9,
  parameter int AW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   seed,
  input  logic [3:0]    bias,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam int XW = $clog2(W);
  localparam logic [XW-1:0] X_LAST = XW'(W - 2);
  localparam logic [AW-1:0] Y_LAST = AW'(H - 2);
  localparam logic [AW-1:0] R_LAST = AW'(H - 1);
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_CARVE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  rows [H];
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [AW-1:0] clr_row;
  logic [AW-1:0] cy;
  logic [XW-1:0] cx;
  logic          accept;
  logic          last_cell;
  logic          carve_n;
  logic          carve_e;

  // Galois form, shifting right: feedback taps applied when bit 0 falls out.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    carve_n   = 1'b0;
    carve_e   = 1'b0;
    last_cell = (cx == X_LAST) && (cy == Y_LAST);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_row == R_LAST) begin
          state_d = S_CARVE;
        end
      end
      S_CARVE: begin
        // Top row can only go east and right column only north, which keeps
        // the result a spanning tree; the top-right corner opens nothing.
        if (cy == AW'(1)) begin
          carve_e = (cx != X_LAST);
        end else if (cx == X_LAST) begin
          carve_n = 1'b1;
        end else if (lfsr[3:0] < bias) begin
          carve_n = 1'b1;
        end else begin
          carve_e = 1'b1;
        end
        if (last_cell) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_CLEAR) || (state_q == S_CARVE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr    <= SEED_DEFAULT;
      clr_row <= '0;
      cx      <= XW'(1);
      cy      <= AW'(1);
      rd_data <= '0;
      for (int i = 0; i < H; i++) begin
        rows[i] <= '1;
      end
    end else begin
      // Read port sees the array as it stands, including mid-generation.
      rd_data <= (int'(rd_addr) < H) ? rows[rd_addr] : '0;

      if (accept) begin
        lfsr    <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
        clr_row <= '0;
        cx      <= XW'(1);
        cy      <= AW'(1);
      end

      case (state_q)
        S_CLEAR: begin
          rows[clr_row] <= '1;
          clr_row       <= clr_row + AW'(1);
        end
        S_CARVE: begin
          rows[cy][cx] <= 1'b0;
          if (carve_e) begin
            rows[cy][cx + XW'(1)] <= 1'b0;
          end
          if (carve_n) begin
            rows[cy - AW'(1)][cx] <= 1'b0;
          end
          lfsr <= lfsr_next;
          if (cx == X_LAST) begin
            cx <= XW'(1);
            cy <= cy + AW'(2);
          end else begin
            cx <= cx + XW'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mazegen_bt.sv
// tb/tb_mazegen_bt.sv - self-checking bench for mazegen_bt (9x9, 5x5, 15x7)
module tb_mazegen_bt;

  logic        clk = 1'b0;
  logic        rst;
  logic        st9, st5, st15;
  logic [15:0] sd9, sd5, sd15;
  logic [3:0]  bs9, bs5, bs15;
  logic [3:0]  ad9;
  logic [2:0]  ad5, ad15;
  logic        by9, by5, by15;
  logic        dn9, dn5, dn15;
  logic [8:0]  rd9;
  logic [4:0]  rd5;
  logic [14:0] rd15;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_rows [9];

  always #5 clk = ~clk;

  mazegen_bt #(.W(9), .H(9)) u9 (
    .clk(clk), .rst(rst), .start(st9), .seed(sd9), .bias(bs9),
    .busy(by9), .done(dn9), .rd_addr(ad9), .rd_data(rd9)
  );
  mazegen_bt #(.W(5), .H(5)) u5 (
    .clk(clk), .rst(rst), .start(st5), .seed(sd5), .bias(bs5),
    .busy(by5), .done(dn5), .rd_addr(ad5), .rd_data(rd5)
  );
  mazegen_bt #(.W(15), .H(7)) u15 (
    .clk(clk), .rst(rst), .start(st15), .seed(sd15), .bias(bs15),
    .busy(by15), .done(dn15), .rd_addr(ad15), .rd_data(rd15)
  );

  function automatic logic get_busy(int inst);
    case (inst)
      5:  return by5;
      15: return by15;
      default: return by9;
    endcase
  endfunction

  function automatic logic get_done(int inst);
    case (inst)
      5:  return dn5;
      15: return dn15;
      default: return dn9;
    endcase
  endfunction

  task automatic set_in(int inst, logic v, logic [15:0] s, logic [3:0] b);
    case (inst)
      5:  begin st5 = v;  sd5 = s;  bs5 = b;  end
      15: begin st15 = v; sd15 = s; bs15 = b; end
      default: begin st9 = v; sd9 = s; bs9 = b; end
    endcase
  endtask

  task automatic read_row(int inst, int a, output logic [14:0] d);
    case (inst)
      5:  ad5 = 3'(a);
      15: ad15 = 3'(a);
      default: ad9 = 4'(a);
    endcase
    @(posedge clk); #1;
    case (inst)
      5:  d = 15'(rd5);
      15: d = rd15;
      default: d = 15'(rd9);
    endcase
  endtask

  // Pulses start for one edge, then counts edges until done is seen.
  task automatic run(int inst, logic [15:0] s, logic [3:0] b,
                     output int lat, output logic b1, output logic d1, output logic ovl);
    set_in(inst, 1'b1, s, b);
    @(posedge clk); #1;
    set_in(inst, 1'b0, s, b);
    b1 = get_busy(inst);
    d1 = get_done(inst);
    ovl = 1'b0;
    lat = 0;
    while (!get_done(inst) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (get_busy(inst) && get_done(inst)) ovl = 1'b1;
    end
  endtask

  // Reference model: walks the odd cells in row-major order, one LFSR step per cell.
  task automatic build_model(int w, int h, logic [15:0] sd, logic [3:0] bs);
    int l;
    l = (sd == 16'h0) ? 'hACE1 : int'(sd);
    for (int y = 0; y < 9; y++) begin
      exp_rows[y] = '0;
      if (y < h) begin
        for (int x = 0; x < w; x++) exp_rows[y][x] = 1'b1;
      end
    end
    for (int y = 1; y < h - 1; y += 2) begin
      for (int x = 1; x < w - 1; x += 2) begin
        exp_rows[y][x] = 1'b0;
        if (y == 1 && x == w - 2) begin
        end else if (y == 1) begin
          exp_rows[y][x + 1] = 1'b0;
        end else if (x == w - 2) begin
          exp_rows[y - 1][x] = 1'b0;
        end else if ((l % 16) < int'(bs)) begin
          exp_rows[y - 1][x] = 1'b0;
        end else begin
          exp_rows[y][x + 1] = 1'b0;
        end
        l = (l % 2 == 1) ? ((l / 2) ^ 'hB400) : (l / 2);
      end
    end
  endtask

  task automatic test_reset;
    logic [14:0] d;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({by9, dn9, by5, dn5, by15, dn15} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000", {by9, dn9, by5, dn5, by15, dn15});
    end
    checks++;
    if ({rd9, rd5, rd15} !== 29'b0) begin
      errors++;
      $display("FAIL reset_rd_data got %h exp 0", {rd9, rd5, rd15});
    end
    rst = 1'b1;
    for (int y = 0; y < 9; y++) begin
      read_row(9, y, d);
      checks++;
      if (d !== 15'h01FF) begin
        errors++;
        $display("FAIL reset_row9 row %0d got %h exp 1ff", y, d);
      end
    end
    for (int y = 0; y < 7; y++) begin
      read_row(15, y, d);
      checks++;
      if (d !== 15'h7FFF) begin
        errors++;
        $display("FAIL reset_row15 row %0d got %h exp 7fff", y, d);
      end
    end
  endtask

  task automatic test_bias0_5x5;
    logic [4:0]  fixed [5];
    logic [14:0] d;
    logic [15:0] s;
    int lat;
    logic b1, d1, ovl;
    fixed[0] = 5'b11111; fixed[1] = 5'b10001; fixed[2] = 5'b10111;
    fixed[3] = 5'b10001; fixed[4] = 5'b11111;
    s = 16'($urandom);
    run(5, s, 4'd0, lat, b1, d1, ovl);
    checks++;
    if (b1 !== 1'b1 || d1 !== 1'b0) begin
      errors++;
      $display("FAIL b0_accept busy/done got %b%b exp 10", b1, d1);
    end
    // done first seen after edge k+H+NC = k+9, i.e. in cycle k+10
    checks++;
    if (lat !== 9 || ovl) begin
      errors++;
      $display("FAIL b0_latency got %0d (overlap %b) exp 9", lat, ovl);
    end
    build_model(5, 5, s, 4'd0);
    for (int y = 0; y < 5; y++) begin
      read_row(5, y, d);
      checks++;
      if (d !== 15'(fixed[y]) || d !== exp_rows[y]) begin
        errors++;
        $display("FAIL b0_row %0d got %b exp %b", y, d[4:0], fixed[y]);
      end
    end
  endtask

  task automatic test_seed_zero;
    logic [14:0] m0 [9];
    logic [14:0] m1 [9];
    int g [9][9];
    int vis [9][9];
    int q [$];
    logic [3:0] b;
    int lat, open_cnt, cells, c, cy, cx, ny, nx;
    logic b1, d1, ovl;
    b = 4'($urandom_range(0, 15));
    run(9, 16'h0000, b, lat, b1, d1, ovl);
    checks++;
    if (lat !== 25 || ovl) begin
      errors++;
      $display("FAIL sz_latency got %0d (overlap %b) exp 25", lat, ovl);
    end
    for (int y = 0; y < 9; y++) read_row(9, y, m0[y]);
    run(9, 16'hACE1, b, lat, b1, d1, ovl);
    for (int y = 0; y < 9; y++) read_row(9, y, m1[y]);
    build_model(9, 9, 16'hACE1, b);
    for (int y = 0; y < 9; y++) begin
      checks++;
      if (m0[y] !== m1[y] || m1[y] !== exp_rows[y]) begin
        errors++;
        $display("FAIL sz_row %0d got %h/%h exp %h", y, m0[y], m1[y], exp_rows[y]);
      end
    end
    open_cnt = 0;
    for (int y = 0; y < 9; y++) begin
      for (int x = 0; x < 9; x++) begin
        g[y][x] = (m0[y][x] == 1'b0) ? 1 : 0;
        vis[y][x] = 0;
        open_cnt += g[y][x];
      end
    end
    checks++;
    if (open_cnt != 31) begin
      errors++;
      $display("FAIL sz_open_count got %0d exp 31", open_cnt);
    end
    if (g[1][1] == 1) begin
      vis[1][1] = 1;
      q.push_back(10);
    end
    while (q.size() > 0) begin
      c = q.pop_front();
      cy = c / 9;
      cx = c % 9;
      for (int k = 0; k < 4; k++) begin
        ny = cy + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
        nx = cx + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
        if (ny >= 0 && ny < 9 && nx >= 0 && nx < 9) begin
          if (g[ny][nx] == 1 && vis[ny][nx] == 0) begin
            vis[ny][nx] = 1;
            q.push_back(ny * 9 + nx);
          end
        end
      end
    end
    cells = 0;
    for (int y = 1; y < 9; y += 2)
      for (int x = 1; x < 9; x += 2) cells += vis[y][x];
    checks++;
    if (cells != 16) begin
      errors++;
      $display("FAIL sz_bfs_reach got %0d exp 16", cells);
    end
  endtask

  task automatic test_restart_ignore;
    logic [15:0] s1, s2;
    logic [3:0] b, b2;
    logic [14:0] d;
    int lat;
    logic b1, d1, ovl;
    s1 = 16'($urandom); s2 = 16'($urandom); b = 4'($urandom); b2 = 4'($urandom);
    set_in(9, 1'b1, s1, b);
    @(posedge clk); #1;
    set_in(9, 1'b0, s1, b);
    lat = 0;
    repeat (12) begin
      @(posedge clk); #1;
      lat++;
    end
    set_in(9, 1'b1, s2, b);
    @(posedge clk); #1;
    lat++;
    set_in(9, 1'b0, s2, b);
    while (!dn9 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 25) begin
      errors++;
      $display("FAIL ign_latency got %0d exp 25", lat);
    end
    build_model(9, 9, s1, b);
    for (int y = 0; y < 9; y++) begin
      read_row(9, y, d);
      checks++;
      if (d !== exp_rows[y]) begin
        errors++;
        $display("FAIL ign_row %0d got %h exp %h", y, d, exp_rows[y]);
      end
    end
    run(9, s2, b2, lat, b1, d1, ovl);
    checks++;
    if (b1 !== 1'b1 || d1 !== 1'b0) begin
      errors++;
      $display("FAIL rs_accept busy/done got %b%b exp 10", b1, d1);
    end
    checks++;
    if (lat !== 25 || ovl) begin
      errors++;
      $display("FAIL rs_latency got %0d (overlap %b) exp 25", lat, ovl);
    end
    build_model(9, 9, s2, b2);
    for (int y = 0; y < 9; y++) begin
      read_row(9, y, d);
      checks++;
      if (d !== exp_rows[y]) begin
        errors++;
        $display("FAIL rs_row %0d got %h exp %h", y, d, exp_rows[y]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s, s2;
    logic [3:0] b;
    logic [14:0] d;
    int lat;
    s = 16'($urandom); s2 = 16'($urandom); b = 4'($urandom);
    set_in(9, 1'b1, s, b);
    @(posedge clk); #1;
    set_in(9, 1'b0, s, b);
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (by9 !== 1'b0 || dn9 !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort busy/done got %b%b exp 00", by9, dn9);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int y = 0; y < 9; y++) begin
      read_row(9, y, d);
      checks++;
      if (d !== 15'h01FF) begin
        errors++;
        $display("FAIL mid_row_ones row %0d got %h exp 1ff", y, d);
      end
    end
    rst = 1'b0;
    set_in(9, 1'b1, s2, b);
    @(posedge clk); #1;
    checks++;
    if (by9 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset busy got %b exp 0", by9);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    set_in(9, 1'b0, s2, b);
    checks++;
    if (by9 !== 1'b1) begin
      errors++;
      $display("FAIL held_start busy got %b exp 1", by9);
    end
    lat = 0;
    while (!dn9 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 25) begin
      errors++;
      $display("FAIL held_latency got %0d exp 25", lat);
    end
    build_model(9, 9, s2, b);
    for (int y = 0; y < 9; y++) begin
      read_row(9, y, d);
      checks++;
      if (d !== exp_rows[y]) begin
        errors++;
        $display("FAIL held_row %0d got %h exp %h", y, d, exp_rows[y]);
      end
    end
  endtask

  task automatic test_asym;
    logic [15:0] s;
    logic [3:0] b;
    logic [14:0] d;
    int lat;
    logic b1, d1, ovl;
    for (int i = 0; i < 50; i++) begin
      s = 16'($urandom);
      b = 4'(i % 16);
      run(15, s, b, lat, b1, d1, ovl);
      checks++;
      if (lat !== 28 || ovl || b1 !== 1'b1 || d1 !== 1'b0) begin
        errors++;
        $display("FAIL asym_timing run %0d lat %0d busy %b done %b overlap %b exp 28 1 0 0",
                 i, lat, b1, d1, ovl);
      end
      build_model(15, 7, s, b);
      for (int y = 0; y < 7; y++) begin
        read_row(15, y, d);
        checks++;
        if (d !== exp_rows[y]) begin
          errors++;
          $display("FAIL asym_row run %0d seed %h bias %0d row %0d got %h exp %h",
                   i, s, b, y, d, exp_rows[y]);
        end
      end
      read_row(15, 7, d);
      checks++;
      if (d !== 15'h0) begin
        errors++;
        $display("FAIL asym_oob got %h exp 0", d);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    st9 = 1'b0; st5 = 1'b0; st15 = 1'b0;
    sd9 = '0; sd5 = '0; sd15 = '0;
    bs9 = '0; bs5 = '0; bs15 = '0;
    ad9 = '0; ad5 = '0; ad15 = '0;
    test_reset;
    test_bias0_5x5;
    test_seed_zero;
    test_restart_ignore;
    test_reset_mid;
    test_asym;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
